// File: rtl/console_uart_rx_pkg.sv
// Shared types and constants for the serial console receive path.
// The divisor default matches the console transmitter so one value sets both.
package console_uart_rx_pkg;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_t;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic [31:0] EMPTY_READ  = 32'h0;
    localparam logic [31:0] MIN_DIV     = 32'd2;
    localparam logic [31:0] DEFAULT_DIV = 32'd53333;

    // Divisor actually used for bit timing; tiny values would break mid-bit sampling.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Parameterised synchronous FIFO with wrap-bit pointers.
// Push while full is dropped unless a pop lands in the same cycle.
module rx_byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        count   = wr_q - rd_q;
        empty_o = (count == '0);
        full_o  = (count == FULL_CNT);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        drop_o  = push_i && full_o && !pop_i;
        head_o  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/console_uart_rx.sv
// 8N1 serial console receiver with a programmable divisor and a byte FIFO
// read through the CPU console data register.
module console_uart_rx #(
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] DEFAULT_DIV = console_uart_rx_pkg::DEFAULT_DIV
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ser_rx_i,
    input  logic [3:0]  reg_div_we_i,
    input  logic [31:0] reg_div_di_i,
    output logic [31:0] reg_div_do_o,
    input  logic        reg_dat_re_i,
    output logic [31:0] reg_dat_do_o,
    output logic        rx_avail_o,
    output logic        overrun_o,
    output logic        frame_err_o
);

    import console_uart_rx_pkg::*;

    logic        sync1_q;
    logic        sync2_q;
    logic [31:0] div_q;
    logic [31:0] wdiv_q;
    logic [31:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    rx_state_t   state_q;
    logic        overrun_q;
    logic        frame_err_q;

    logic        rx;
    logic        stop_sample;
    logic        push;
    logic        frame_set;
    logic        pop_accepted;
    logic [7:0]  fifo_head;
    logic        fifo_empty;
    logic        fifo_drop;
    logic        unused_fifo_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_rx_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= DEFAULT_DIV;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_div_we_i[i]) begin
                    div_q[8*i +: 8] <= reg_div_di_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rx           = sync2_q;
        stop_sample  = (state_q == StStop) && (cnt_q == '0);
        push         = stop_sample && rx;
        frame_set    = stop_sample && !rx;
        pop_accepted = reg_dat_re_i && !fifo_empty;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            wdiv_q  <= DEFAULT_DIV;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rx) begin
                        wdiv_q  <= eff_div(div_q);
                        cnt_q   <= eff_div(div_q) >> 1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else if (rx) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= wdiv_q - 32'd1;
                        bit_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else begin
                        shreg_q[bit_q] <= rx;
                        cnt_q          <= wdiv_q - 32'd1;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sticky flags: a coincident set beats the pop-side clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overrun_q <= 1'b1;
            end else if (pop_accepted) begin
                overrun_q <= 1'b0;
            end
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (pop_accepted) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    rx_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (shreg_q),
        .pop_i       (reg_dat_re_i),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (unused_fifo_full),
        .drop_o      (fifo_drop)
    );

    assign reg_div_do_o = div_q;
    assign reg_dat_do_o = fifo_empty ? EMPTY_READ : {24'h0, fifo_head};
    assign rx_avail_o   = !fifo_empty;
    assign overrun_o    = overrun_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_console_uart_rx.sv
// Self-checking bench for console_uart_rx: frame-level stimulus against a
// queue-based model of the receive buffer and its sticky flags.
module tb_console_uart_rx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ser_rx = 1'b1;
    logic [3:0]  div_we = 4'h0;
    logic [31:0] div_di = 32'h0;
    logic [31:0] div_do;
    logic        dat_re = 1'b0;
    logic [31:0] dat_do;
    logic        rx_avail;
    logic        overrun;
    logic        frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    always #5 clk = ~clk;

    console_uart_rx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ser_rx_i     (ser_rx),
        .reg_div_we_i (div_we),
        .reg_div_di_i (div_di),
        .reg_div_do_o (div_do),
        .reg_dat_re_i (dat_re),
        .reg_dat_do_o (dat_do),
        .rx_avail_o   (rx_avail),
        .overrun_o    (overrun),
        .frame_err_o  (frame_err)
    );

    // Model: a completed frame either lands in the buffer, overflows, or is a framing error.
    function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] model_pop();
        logic [31:0] v;
        if (mq.size() == 0) return 32'h0;
        v = {24'h0, mq.pop_front()};
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] model_head();
        if (mq.size() == 0) return 32'h0;
        return {24'h0, mq[0]};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
    endfunction

    task automatic write_div(input logic [3:0] we, input logic [31:0] di);
        div_we = we;
        div_di = di;
        @(negedge clk);
        div_we = 4'h0;
    endtask

    task automatic pulse_re();
        dat_re = 1'b1;
        @(negedge clk);
        dat_re = 1'b0;
    endtask

    // One 8N1 frame, one negedge per cycle; optional pop/divisor write at a given cycle.
    // avb/ava: rx_avail just before and just after the stop-bit sample edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div,
                              input int pop_c, input int wr_c, input logic [31:0] wr_val,
                              input int idle, output logic avb, output logic ava);
        int stop_c;
        stop_c = 3 + div / 2 + 9 * div;
        avb = 1'bx;
        ava = 1'bx;
        for (int c = 0; c <= 10 * div; c++) begin
            @(negedge clk);
            if (c < div) ser_rx = 1'b0;
            else if (c < 9 * div) ser_rx = b[(c / div) - 1];
            else if (c < 10 * div) ser_rx = stop_bit;
            else ser_rx = 1'b1;
            dat_re = (c == pop_c);
            div_we = (c == wr_c) ? 4'hF : 4'h0;
            div_di = wr_val;
            if (c == stop_c) avb = rx_avail;
            if (c == stop_c + 1) ava = rx_avail;
        end
        dat_re = 1'b0;
        div_we = 4'h0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        total_cnt++;
        if (div_do !== 32'd53333) $display("FAIL reset_div: got %0d want 53333", div_do);
        else pass_cnt++;
        total_cnt++;
        if (dat_do !== 32'h0) $display("FAIL reset_dat: got %h want 0", dat_do);
        else pass_cnt++;
        total_cnt++;
        if (rx_avail !== 1'b0) $display("FAIL reset_avail: got %b want 0", rx_avail);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun);
        else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err);
        else pass_cnt++;
    endtask

    task automatic test_div_lanes();
        write_div(4'hF, 32'd16);
        total_cnt++;
        if (div_do !== 32'd16) $display("FAIL div_full: got %h want %h", div_do, 32'd16);
        else pass_cnt++;
        write_div(4'b0010, 32'hDEAD_AB77);
        total_cnt++;
        if (div_do !== 32'h0000_AB10) $display("FAIL div_lane1: got %h want 0000ab10", div_do);
        else pass_cnt++;
        write_div(4'b0011, 32'h0000_0010);
        total_cnt++;
        if (div_do !== 32'd16) $display("FAIL div_restore: got %h want %h", div_do, 32'd16);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic avb, ava;
        logic [31:0] exp;
        send_frame(8'hA5, 1'b1, 16, -1, -1, 0, 2, avb, ava);
        model_frame(8'hA5, 1'b1);
        total_cnt++;
        if (avb !== 1'b0 || ava !== 1'b1)
            $display("FAIL a5_avail_timing: got %b%b want 01", avb, ava);
        else pass_cnt++;
        exp = model_pop();
        total_cnt++;
        if (dat_do !== exp) $display("FAIL a5_data: got %h want %h", dat_do, exp);
        else pass_cnt++;
        pulse_re();
        total_cnt++;
        if (dat_do !== 32'h0 || rx_avail !== 1'b0)
            $display("FAIL a5_after_pop: got %h/%b want 0/0", dat_do, rx_avail);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        logic avb, ava;
        logic [31:0] exp;
        ser_rx = 1'b0;
        repeat (5) @(negedge clk);
        ser_rx = 1'b1;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (rx_avail !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL glitch_quiet: got avail=%b ferr=%b want 0/0", rx_avail, frame_err);
        else pass_cnt++;
        send_frame(8'h3C, 1'b1, 16, -1, -1, 0, 2, avb, ava);
        model_frame(8'h3C, 1'b1);
        exp = model_pop();
        total_cnt++;
        if (dat_do !== exp) $display("FAIL glitch_next: got %h want %h", dat_do, exp);
        else pass_cnt++;
        pulse_re();
    endtask

    task automatic test_overrun();
        logic avb, ava;
        logic [31:0] exp;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, 16, -1, -1, 0, 2, avb, ava);
            model_frame(8'(i), 1'b1);
        end
        total_cnt++;
        if (overrun !== m_ovr) $display("FAIL ovr_set: got %b want %b", overrun, m_ovr);
        else pass_cnt++;
        for (int i = 0; i < 9; i++) begin
            exp = model_pop();
            total_cnt++;
            if (dat_do !== exp) $display("FAIL ovr_pop%0d: got %h want %h", i, dat_do, exp);
            else pass_cnt++;
            pulse_re();
            if (i == 0) begin
                total_cnt++;
                if (overrun !== m_ovr) $display("FAIL ovr_clear: got %b want %b", overrun, m_ovr);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_frame_err();
        logic avb, ava;
        logic [31:0] exp;
        send_frame(8'h7E, 1'b0, 16, -1, -1, 0, 32, avb, ava);
        model_frame(8'h7E, 1'b0);
        total_cnt++;
        if (rx_avail !== 1'b0 || frame_err !== m_ferr)
            $display("FAIL ferr_set: got avail=%b ferr=%b want 0/%b", rx_avail, frame_err, m_ferr);
        else pass_cnt++;
        send_frame(8'h42, 1'b1, 16, -1, -1, 0, 2, avb, ava);
        model_frame(8'h42, 1'b1);
        total_cnt++;
        if (frame_err !== m_ferr) $display("FAIL ferr_sticky: got %b want %b", frame_err, m_ferr);
        else pass_cnt++;
        exp = model_pop();
        total_cnt++;
        if (dat_do !== exp) $display("FAIL ferr_next: got %h want %h", dat_do, exp);
        else pass_cnt++;
        pulse_re();
        total_cnt++;
        if (frame_err !== m_ferr) $display("FAIL ferr_clear: got %b want %b", frame_err, m_ferr);
        else pass_cnt++;
    endtask

    task automatic test_pop_at_full();
        logic avb, ava;
        logic [31:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 16, -1, -1, 0, 2, avb, ava);
            model_frame(b, 1'b1);
        end
        // Pop lands on the same edge as the stop-bit sample of the ninth byte.
        send_frame(8'hEE, 1'b1, 16, 3 + 8 + 9 * 16, -1, 0, 2, avb, ava);
        exp = model_pop();
        model_frame(8'hEE, 1'b1);
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL full_pop_ovr: got %b want 0", overrun);
        else pass_cnt++;
        for (int i = 0; i <= DEPTH; i++) begin
            exp = model_pop();
            total_cnt++;
            if (dat_do !== exp) $display("FAIL full_pop_drain%0d: got %h want %h", i, dat_do, exp);
            else pass_cnt++;
            pulse_re();
        end
    endtask

    task automatic test_div_change();
        logic avb, ava;
        logic [31:0] exp;
        send_frame(8'h96, 1'b1, 16, -1, 50, 32'd8, 2, avb, ava);
        model_frame(8'h96, 1'b1);
        total_cnt++;
        if (div_do !== 32'd8) $display("FAIL divchg_reg: got %0d want 8", div_do);
        else pass_cnt++;
        send_frame(8'h5B, 1'b1, 8, -1, -1, 0, 2, avb, ava);
        model_frame(8'h5B, 1'b1);
        for (int i = 0; i < 2; i++) begin
            exp = model_pop();
            total_cnt++;
            if (dat_do !== exp) $display("FAIL divchg_byte%0d: got %h want %h", i, dat_do, exp);
            else pass_cnt++;
            pulse_re();
        end
        write_div(4'hF, 32'd16);
    endtask

    task automatic test_random();
        logic avb, ava;
        logic [31:0] exp;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            logic ok;
            int npop;
            b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, 16, -1, -1, 0, 32, avb, ava);
            model_frame(b, ok);
            total_cnt++;
            if (frame_err !== m_ferr || overrun !== m_ovr || rx_avail !== (mq.size() != 0))
                $display("FAIL rand_flags%0d: got ferr=%b ovr=%b avail=%b want %b/%b/%b", i,
                         frame_err, overrun, rx_avail, m_ferr, m_ovr, mq.size() != 0);
            else pass_cnt++;
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                exp = model_pop();
                total_cnt++;
                if (dat_do !== exp) $display("FAIL rand_pop%0d_%0d: got %h want %h", i, p, dat_do, exp);
                else pass_cnt++;
                pulse_re();
            end
        end
        while (mq.size() != 0) begin
            exp = model_pop();
            total_cnt++;
            if (dat_do !== exp) $display("FAIL rand_drain: got %h want %h", dat_do, exp);
            else pass_cnt++;
            pulse_re();
        end
        pulse_re();
        model_reset();
    endtask

    task automatic test_reset_mid();
        logic avb, ava;
        logic [31:0] exp;
        send_frame(8'h11, 1'b1, 16, -1, -1, 0, 2, avb, ava);
        send_frame(8'h22, 1'b0, 16, -1, -1, 0, 32, avb, ava);
        write_div(4'hF, 32'd20);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ser_rx = (c < 16) ? 1'b0 : 1'b1;
        end
        rst = 1'b1;
        ser_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total_cnt++;
        if (div_do !== 32'd53333 || dat_do !== 32'h0 || rx_avail !== 1'b0 ||
            overrun !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL midrst_state: got div=%0d dat=%h av=%b ovr=%b ferr=%b want 53333/0/0/0/0",
                     div_do, dat_do, rx_avail, overrun, frame_err);
        else pass_cnt++;
        write_div(4'hF, 32'd16);
        send_frame(8'hC3, 1'b1, 16, -1, -1, 0, 2, avb, ava);
        model_frame(8'hC3, 1'b1);
        exp = model_pop();
        total_cnt++;
        if (dat_do !== exp) $display("FAIL midrst_after: got %h want %h", dat_do, exp);
        else pass_cnt++;
        pulse_re();
    endtask

    initial begin
        test_reset();
        test_div_lanes();
        test_single();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_pop_at_full();
        test_div_change();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
